// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative double-dabble binary-to-BCD converter, one adjust-and-shift step per clock
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVF
);
    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   bin_sh;
    logic [SCR_W-1:0]   scratch;
    logic               ovf_acc;
    logic [CNT_W-1:0]   cnt;

    logic [SCR_W-1:0]   adjusted;
    logic [SCR_W-1:0]   shifted;
    logic               carry_out;

    // All digits are adjusted from the pre-step value, then shifted as one word
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            else
                adjusted[4*i +: 4] = scratch[4*i +: 4];
        end
        carry_out = adjusted[SCR_W-1];
        shifted   = {adjusted[SCR_W-2:0], bin_sh[BIN_W-1]};
    end

    assign BUSY = (state == RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            bin_sh  <= '0;
            scratch <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
            DONE    <= 1'b0;
            BCD     <= '0;
            OVF     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        bin_sh  <= BIN;
                        scratch <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    bin_sh  <= bin_sh << 1;
                    scratch <= shifted;
                    ovf_acc <= ovf_acc | carry_out;
                    cnt     <= cnt + CNT_W'(1);
                    // Result and overflow are published only on the final step
                    if (cnt == LAST) begin
                        BCD   <= shifted;
                        OVF   <= ovf_acc | carry_out;
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, busy_a, done_a, ovf_a;
    logic [7:0]  bin_a = '0;
    logic [11:0] bcd_a;
    logic        start_b = 1'b0, busy_b, done_b, ovf_b;
    logic [7:0]  bin_b = '0;
    logic [7:0]  bcd_b;
    logic        start_c = 1'b0, busy_c, done_c, ovf_c;
    logic [15:0] bin_c = '0;
    logic [19:0] bcd_c;
    logic        start_d = 1'b0, busy_d, done_d, ovf_d;
    logic [0:0]  bin_d = '0;
    logic [3:0]  bcd_d;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .CLK(clk), .RST(rst), .START(start_a), .BIN(bin_a),
        .BUSY(busy_a), .DONE(done_a), .BCD(bcd_a), .OVF(ovf_a));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
        .CLK(clk), .RST(rst), .START(start_b), .BIN(bin_b),
        .BUSY(busy_b), .DONE(done_b), .BCD(bcd_b), .OVF(ovf_b));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .CLK(clk), .RST(rst), .START(start_c), .BIN(bin_c),
        .BUSY(busy_c), .DONE(done_c), .BCD(bcd_c), .OVF(ovf_c));
    bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1)) u_d (
        .CLK(clk), .RST(rst), .START(start_d), .BIN(bin_d),
        .BUSY(busy_d), .DONE(done_d), .BCD(bcd_d), .OVF(ovf_d));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] dec3(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic convert_a(input logic [7:0] v, input logic [11:0] exp_bcd,
                             input logic exp_ovf, input string tag);
        int lat;
        start_a = 1'b1; bin_a = v;
        step();
        start_a = 1'b0;
        check({tag, " busy"}, busy_a, 1);
        lat = 0;
        do begin step(); lat++; end while (!done_a && lat < 40);
        check({tag, " lat"}, lat, 8);
        check({tag, " bcd"}, bcd_a, exp_bcd);
        check({tag, " ovf"}, ovf_a, exp_ovf);
    endtask

    task automatic convert_b(input logic [7:0] v, input logic [7:0] exp_bcd,
                             input logic exp_ovf, input string tag);
        int lat;
        start_b = 1'b1; bin_b = v;
        step();
        start_b = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!done_b && lat < 40);
        check({tag, " lat"}, lat, 8);
        check({tag, " bcd"}, bcd_b, exp_bcd);
        check({tag, " ovf"}, ovf_b, exp_ovf);
    endtask

    task automatic convert_c(input logic [15:0] v, input logic [19:0] exp_bcd,
                             input logic exp_ovf, input string tag);
        int lat;
        start_c = 1'b1; bin_c = v;
        step();
        start_c = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!done_c && lat < 60);
        check({tag, " lat"}, lat, 16);
        check({tag, " bcd"}, bcd_c, exp_bcd);
        check({tag, " ovf"}, ovf_c, exp_ovf);
    endtask

    task automatic convert_d(input logic [0:0] v, input logic [3:0] exp_bcd, input string tag);
        int lat;
        start_d = 1'b1; bin_d = v;
        step();
        start_d = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!done_d && lat < 20);
        check({tag, " lat"}, lat, 1);
        check({tag, " bcd"}, bcd_d, exp_bcd);
        check({tag, " ovf"}, ovf_d, 0);
    endtask

    initial begin
        int dones;
        step(); step();
        check("rst busy", busy_a, 0);
        check("rst done", done_a, 0);
        check("rst bcd", bcd_a, 0);
        check("rst ovf", ovf_a, 0);
        start_a = 1'b1;
        step();
        check("rst overrides start", busy_a, 0);
        start_a = 1'b0;
        rst = 1'b0;
        step();

        // 255: BUSY stays high for 8 cycles, DONE on the 8th edge
        start_a = 1'b1; bin_a = 8'd255;
        step();
        start_a = 1'b0; bin_a = 8'd0;
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) begin
                check("t255 busy run", busy_a, 1);
                check("t255 done low", done_a, 0);
                check("t255 bcd hidden", bcd_a, 0);
            end
            step();
        end
        check("t255 done", done_a, 1);
        check("t255 busy end", busy_a, 0);
        check("t255 bcd", bcd_a, 12'h255);
        check("t255 ovf", ovf_a, 0);
        step();
        check("t255 done pulse", done_a, 0);
        check("t255 bcd hold", bcd_a, 12'h255);

        // Back-to-back sweep: each new START lands in the previous DONE cycle
        for (int v = 0; v < 256; v++)
            convert_a(8'(v), dec3(v), 1'b0, "sweep");
        step();

        // START during RUN is ignored, BIN is not re-sampled
        start_a = 1'b1; bin_a = 8'd137;
        step();
        dones = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2 || i == 5) begin start_a = 1'b1; bin_a = 8'd42; end
            else start_a = 1'b0;
            step();
            if (done_a) dones++;
            if (i == 8) check("ign done edge", done_a, 1);
        end
        start_a = 1'b0;
        check("ign bcd", bcd_a, 12'h137);
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_a) dones++;
        end
        check("ign single done", dones, 1);
        check("ign idle", busy_a, 0);

        // Reset on the 4th RUN cycle aborts the conversion
        start_a = 1'b1; bin_a = 8'd200;
        step();
        start_a = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", busy_a, 0);
        check("abort done", done_a, 0);
        check("abort bcd", bcd_a, 0);
        check("abort ovf", ovf_a, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_a) dones++;
        end
        check("abort no done", dones, 0);
        convert_a(8'd7, 12'h007, 1'b0, "post rst");

        // Two digits: overflow wraps mod 100 and clears on the next conversion
        convert_b(8'd100, 8'h00, 1'b1, "d2 100");
        convert_b(8'd99, 8'h99, 1'b0, "d2 99");
        convert_b(8'd255, 8'h55, 1'b1, "d2 255");
        convert_b(8'd0, 8'h00, 1'b0, "d2 0");

        convert_c(16'd65535, 20'h65535, 1'b0, "w16 65535");
        convert_c(16'd10203, 20'h10203, 1'b0, "w16 10203");

        convert_d(1'b1, 4'h1, "w1 one");
        convert_d(1'b0, 4'h0, "w1 zero");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
